// File: rtl/crc8_frame_arbiter.sv
// ============================================================================
// Module   : crc8_frame_arbiter
// Purpose  : Round-robin, frame-locked sharing of one CRC-8 engine among NREQ
//            byte-stream requesters. Define CRC8_ONECYCLE_EN for a
//            byte-per-cycle engine instead of the 8-step bit-serial one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_frame_arbiter #(
  parameter int         NREQ = 2,
  parameter int         IDW  = 1,
  parameter logic [7:0] POLY = 8'h8B,
  parameter logic [7:0] INIT = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              crc_valid,
  output logic [7:0]        crc_out,
  output logic [IDW-1:0]    crc_id,
  input  logic              crc_ready,
  output logic              busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_BYTE_WAIT = 2'd1;
`ifndef CRC8_ONECYCLE_EN
  localparam logic [1:0] S_SHIFT     = 2'd2;
`endif
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant;
  logic [7:0]     r_crc;
`ifndef CRC8_ONECYCLE_EN
  logic [7:0]     r_shift;
  logic [2:0]     r_cnt;
  logic           r_last;
`endif

  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic           w_sel_valid;
  logic [7:0]     w_sel_data;
  logic           w_sel_last;
  logic [IDW-1:0] w_next_ptr;

  // One MSB-first bit step of the CRC register.
  function automatic logic [7:0] crc_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

`ifdef CRC8_ONECYCLE_EN
  function automatic logic [7:0] crc_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int k = 7; k >= 0; k--) begin
      c = crc_bit(c, d[k]);
    end
    return c;
  endfunction
`endif

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NREQ) begin
        v_idx = v_idx - NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (i == v_idx) && req_valid[i]) begin
          w_found = 1'b1;
          w_pick  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = 8'h00;
    w_sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[8*i +: 8];
        w_sel_last  = req_last[i];
      end
    end
  end

  assign w_next_ptr = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_crc    <= INIT;
`ifndef CRC8_ONECYCLE_EN
      r_shift  <= 8'h00;
      r_cnt    <= 3'd0;
      r_last   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_crc   <= INIT;
            r_state <= S_BYTE_WAIT;
          end
        end
        S_BYTE_WAIT: begin
          if (w_sel_valid) begin
`ifdef CRC8_ONECYCLE_EN
            r_crc   <= crc_byte(r_crc, w_sel_data);
            r_state <= w_sel_last ? S_DONE : S_BYTE_WAIT;
`else
            r_shift <= w_sel_data;
            r_last  <= w_sel_last;
            r_cnt   <= 3'd0;
            r_state <= S_SHIFT;
`endif
          end
        end
`ifndef CRC8_ONECYCLE_EN
        S_SHIFT: begin
          r_crc   <= crc_bit(r_crc, r_shift[7]);
          r_shift <= {r_shift[6:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= r_last ? S_DONE : S_BYTE_WAIT;
          end
        end
`endif
        S_DONE: begin
          if (crc_ready) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (r_state == S_BYTE_WAIT) && (r_grant == IDW'(i));
    end
  end

  // Result outputs read as zero outside DONE so reset and idle look identical.
  assign crc_valid = (r_state == S_DONE);
  assign crc_out   = (r_state == S_DONE) ? r_crc : 8'h00;
  assign crc_id    = (r_state == S_DONE) ? r_grant : '0;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc8_frame_arbiter.sv
// ============================================================================
// Module   : tb_crc8_frame_arbiter
// Purpose  : Self-checking bench for crc8_frame_arbiter with a CRC scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc8_frame_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
`ifdef CRC8_ONECYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 9;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              crc_valid;
  logic [7:0]        crc_out;
  logic [IDW-1:0]    crc_id;
  logic              crc_ready;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IDW+7:0] sb_q[$];
  logic [7:0]     m_crc [NREQ];
  bit             m_in  [NREQ];

  crc8_frame_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .crc_valid (crc_valid),
    .crc_out   (crc_out),
    .crc_id    (crc_id),
    .crc_ready (crc_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: byte-wise XOR then eight shifts.
  function automatic logic [7:0] model_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) begin
      r = r[7] ? ((r << 1) ^ 8'h8B) : (r << 1);
    end
    return r;
  endfunction

  // Waits up to maxc falling edges for req_ready[idx] (which=0) or crc_valid (which=1).
  task automatic wait_sig(input string tag, input int which, input int idx, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if ((which == 0 && req_ready[idx]) || (which == 1 && crc_valid)) begin
        n = k;
        break;
      end
    end
    if (n < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  // Monitor: models every accepted byte and scores each consumed CRC.
  initial begin
    logic [7:0]     c;
    logic [IDW+7:0] e;
    for (int i = 0; i < NREQ; i++) begin
      m_in[i]  = 1'b0;
      m_crc[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NREQ; i++) m_in[i] = 1'b0;
      end else begin
        check("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            c = model_crc(m_in[i] ? m_crc[i] : 8'hFF, req_data[8*i +: 8]);
            if (req_last[i]) begin
              sb_q.push_back({IDW'(i), c});
              m_in[i] = 1'b0;
            end else begin
              m_crc[i] = c;
              m_in[i]  = 1'b1;
            end
          end
        end
        if (crc_valid && crc_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_crc", crc_out, e[7:0]);
            check("sb_id", crc_id, e[IDW+7:8]);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; crc_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", crc_valid, 0);
    check("rst_out", crc_out, 0);
    check("rst_id", crc_id, 0);
    check("rst_busy", busy, 0);
    step(); rst = 1'b0;

    // 1: single-byte frame 0x57 from req0
    set_req(0, 1'b1, 8'h57, 1'b1);
    wait_sig("t1_ready", 0, 0, 10, n);
    check("t1_ready_lat", n, 2);
    step(); set_req(0, 1'b0, 8'h00, 1'b0);
    wait_sig("t1_crc", 1, 0, 20, n);
    check("t1_crc_lat", n, LAT);
    check("t1_crc", crc_out, 8'h0E);
    check("t1_id", crc_id, 0);
    step();

    // 2: two-byte frame 0x57 0x57 from req1
    set_req(1, 1'b1, 8'h57, 1'b0);
    wait_sig("t2_ready", 0, 1, 10, n);
    step(); set_req(1, 1'b1, 8'h57, 1'b1);
    wait_sig("t2_ready2", 0, 1, 20, n);
    check("t2_reready_lat", n, LAT);
    step(); set_req(1, 1'b0, 8'h00, 1'b0);
    wait_sig("t2_crc", 1, 0, 20, n);
    check("t2_crc", crc_out, 8'hD4);
    check("t2_id", crc_id, 1);
    step();

    // 3: both requesters continuously valid with 1-byte 0x00 frames
    set_req(0, 1'b1, 8'h00, 1'b1);
    set_req(1, 1'b1, 8'h00, 1'b1);
    for (int f = 0; f < 4; f++) begin
      wait_sig("t3_crc", 1, 0, 40, n);
      check("t3_id", crc_id, f % 2);
      check("t3_crc", crc_out, 8'h1F);
      step();
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    step();

    // 4: consumer stalls the result for five cycles
    crc_ready = 1'b0;
    set_req(0, 1'b1, 8'h57, 1'b1);
    wait_sig("t4_ready", 0, 0, 10, n);
    step(); set_req(0, 1'b0, 8'h00, 1'b0);
    wait_sig("t4_crc", 1, 0, 20, n);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        step();
        if (k == 5) crc_ready = 1'b1;
        @(negedge clk);
      end
      check("t4_hold_valid", crc_valid, 1);
      check("t4_hold_crc", crc_out, 8'h0E);
      check("t4_hold_id", crc_id, 0);
      check("t4_no_ready", req_ready, 0);
    end
    step(); @(negedge clk);
    check("t4_idle_valid", crc_valid, 0);
    check("t4_idle_busy", busy, 0);
    step();

    // 5: reset in the middle of req1's first byte
    set_req(1, 1'b1, 8'h57, 1'b0);
    wait_sig("t5_ready", 0, 1, 10, n);
    step(); set_req(1, 1'b0, 8'h00, 1'b0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("t5_ready", req_ready, 0);
    check("t5_valid", crc_valid, 0);
    check("t5_out", crc_out, 0);
    check("t5_id", crc_id, 0);
    check("t5_busy", busy, 0);
    step();
    set_req(0, 1'b1, 8'h00, 1'b1);
    set_req(1, 1'b1, 8'h00, 1'b1);
    wait_sig("t5_crc0", 1, 0, 20, n);
    check("t5_first_id", crc_id, 0);
    step(); set_req(0, 1'b0, 8'h00, 1'b0);
    wait_sig("t5_crc1", 1, 0, 30, n);
    check("t5_id1", crc_id, 1);
    check("t5_crc1", crc_out, 8'h1F);
    step(); set_req(1, 1'b0, 8'h00, 1'b0);
    step();

    // 6: req0 stalls between bytes while req1 waits
    set_req(0, 1'b1, 8'h57, 1'b0);
    set_req(1, 1'b1, 8'h00, 1'b1);
    wait_sig("t6_ready", 0, 0, 10, n);
    check("t6_ready_lat", n, 2);
    step(); set_req(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t6_no_ready1", req_ready[1], 0);
      check("t6_busy", busy, 1);
      step();
    end
    check("t6_hold_bw", req_ready[0], 1);
    set_req(0, 1'b1, 8'h57, 1'b1);
    wait_sig("t6_ready2", 0, 0, 10, n);
    check("t6_ready2_lat", n, 1);
    step(); set_req(0, 1'b0, 8'h00, 1'b0);
    wait_sig("t6_crc0", 1, 0, 20, n);
    check("t6_crc0", crc_out, 8'hD4);
    check("t6_id0", crc_id, 0);
    wait_sig("t6_ready1", 0, 1, 10, n);
    step(); set_req(1, 1'b0, 8'h00, 1'b0);
    wait_sig("t6_crc1", 1, 0, 20, n);
    check("t6_crc1", crc_out, 8'h1F);
    check("t6_id1", crc_id, 1);
    step(); step();

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
